// File: rtl/muldiv_pkg.sv
// Shared op codes and state encoding for the iterative HI/LO multiply/divide unit.
// The controller imports the same op constants so its encoding always matches.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative HI/LO unit: radix-2 shift-add multiply and restoring divide, one bit per cycle,
// both working on unsigned magnitudes in a single shared 2*WIDTH shift register.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic [2*WIDTH-1:0]     acc;
    logic [WIDTH-1:0]       opnd;
    logic                   is_div;
    logic                   neg_lo;
    logic                   neg_hi;

    logic                   signed_op;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         rem_sh;
    logic                   rem_ge;
    logic [WIDTH-1:0]       rem_new;
    logic [2*WIDTH-1:0]     div_next;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_sh >= {1'b0, opnd});
        rem_new  = WIDTH'(rem_ge ? (rem_sh - {1'b0, opnd}) : rem_sh);
        div_next = {rem_new, acc[WIDTH-2:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            MD_MULT, MD_MULTU: begin
                                opnd   <= a_mag;
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                is_div <= 1'b0;
                                neg_lo <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_hi <= 1'b0;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                opnd   <= b_mag;
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                is_div <= 1'b1;
                                // Divide by zero keeps the all-ones quotient regardless of sign.
                                neg_lo <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                                neg_hi <= signed_op && a[WIDTH-1];
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi, lo} <= neg_lo ? -acc : acc;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
